phy_tx_sched: RTL and testbench
===============================

Name: phy_tx_sched

Overview:
Transmit-side link scheduler for the two-lane PHY. It shares one byte-wide serializer path between lane 0 and lane 1 byte sources using round-robin arbitration. It sequences link bring-up by sending a comma (K-char 0xBC) training burst, fills empty slots with comma idles, and forces periodic comma skips so the receiver keeps alignment. It sits between the lane byte sources and the parallel-to-serial stage, in the clk_8f domain.

Parameters:
SYNC_COUNT, 4, number of commas emitted in the SYNC state before data is allowed (1..255)
SKIP_PERIOD, 16, maximum consecutive data bytes before a forced comma; 0 disables skips
COMMA, 8'hBC, K-character used for sync, idle and skip slots

Ports:
clk_8f  input  1  single clock; all logic rising-edge
reset  input  1  synchronous, active-high reset
enable  input  1  link enable; 0 holds the link down
data_in_0  input  8  lane 0 byte
valid_in_0  input  1  lane 0 byte available
ready_out_0  output  1  lane 0 byte taken this cycle (combinational)
data_in_1  input  8  lane 1 byte
valid_in_1  input  1  lane 1 byte available
ready_out_1  output  1  lane 1 byte taken this cycle (combinational)
ser_ready  input  1  serializer accepts ser_data this cycle
ser_data  output  8  byte to serializer (registered)
ser_valid  output  1  ser_data holds a byte (registered)
ser_k  output  1  1 = ser_data is a K-char (comma); 0 = lane data
ser_lane  output  1  source lane of a data byte; 0 when ser_k=1
link_state  output  2  0 IDLE, 1 SYNC, 2 ACTIVE
sync_done  output  1  1 while in ACTIVE

Behaviour:
- Reset (synchronous, any state): ser_data=0, ser_valid=0, ser_k=0, ser_lane=0, link_state=IDLE, sync_done=0, sync counter=0, skip counter=0, last_grant=1 (lane 0 wins the first tie). Reset overrides every other input on the same edge.
- Output register: one entry. load = ~ser_valid | ser_ready. A new byte is written only when load=1 and a slot is produced. When load=1 and no slot is produced, ser_valid goes to 0 on the next edge. ser_data, ser_k and ser_lane are stable while ser_valid=1 and ser_ready=0.
- Latency: a lane byte taken (ready_out_x=1) at edge N appears on ser_data after edge N, with ser_k=0 and ser_lane=x.
- IDLE: produces no slots; ready_out_0=ready_out_1=0. On enable=1, go to SYNC with the sync counter cleared.
- SYNC: on each load cycle, emit COMMA with ser_k=1 and increment the sync counter. After the SYNC_COUNT-th comma is loaded, go to ACTIVE on that edge. Lane readies stay 0.
- ACTIVE: on each load cycle, exactly one slot is produced:
  - Forced skip: when SKIP_PERIOD>0 and skip counter == SKIP_PERIOD, emit COMMA with ser_k=1, clear the counter, and keep both readies at 0.
  - Otherwise, if any valid_in_x=1, grant a lane:
    - only one lane valid: grant that lane;
    - both valid: grant ~last_grant.
    - On a grant: ready_out_g=1, load data_in_g, set last_grant=g, increment skip counter (saturating).
  - Otherwise, no lane valid: emit a COMMA idle and clear the skip counter.
- Data bytes equal to 0xBC are ordinary data (ser_k=0). They are never suppressed and never count as a skip.
- ready_out_x is 0 whenever load=0, reset=1 or enable=0. Each lane is granted at most once per cycle.
- enable falling in SYNC or ACTIVE: no new slot is produced from that cycle onward. Next state is IDLE, and the sync and skip counters clear. A byte already in the output register is held until ser_ready, then ser_valid drops. Re-enable always repeats the full SYNC burst.
- Counter widths: sync counter 8 bits; skip counter wide enough to hold SKIP_PERIOD.

Test Plan:
- Reset/bring-up: reset=1 for 4 cycles, then enable=1 with ser_ready=1 -> outputs 0 during reset; exactly 4 consecutive 0xBC with ser_k=1; link_state goes 0→1→2; sync_done=1 after the 4th comma.
- Single lane: ACTIVE, valid_in_0=1 with data 0xDD, valid_in_1=0 -> ready_out_0=1; next cycle ser_data=0xDD, ser_k=0, ser_lane=0. Both valids low -> 0xBC with ser_k=1.
- Round-robin: both lanes valid with streams 0xEC,0xAC (lane 0) and 0xBC,0x0C (lane 1) -> output 0xEC(L0), 0xBC(L1, ser_k=0), 0xAC(L0), 0x0C(L1). Grants strictly alternate.
- Backpressure: ser_ready=0 for 5 cycles while 0x99 is held -> ser_data stays 0x99, both readies 0, no byte lost or duplicated. The next byte 0x11 appears the cycle after ser_ready returns.
- Skip insertion: SKIP_PERIOD=16, both lanes valid continuously -> exactly one comma after every 16 data bytes; readies low in the skip cycle; arbitration order resumes unchanged.
- Mid-operation drop: deassert enable in ACTIVE with ser_ready=0 -> held byte is delivered once, then ser_valid=0 and link_state=IDLE. Re-enable -> 4 fresh commas. A reset pulse mid-SYNC -> everything returns to reset values.

Source files
------------

// File: rtl/phy_tx_sched.sv
// Transmit-side link scheduler for the two-lane PHY.
// Lane 0 and lane 1 share one byte-wide serializer path through round-robin
// arbitration. The block also runs link bring-up: a comma training burst
// comes first, empty slots are filled with comma idles, and a comma is forced
// after a run of data bytes so the receiver keeps its alignment.
module phy_tx_sched #(
  parameter int unsigned SYNC_COUNT  = 4,      // commas sent in SYNC (1..255)
  parameter int unsigned SKIP_PERIOD = 16,     // max data run before a forced comma; 0 disables
  parameter logic [7:0]  COMMA       = 8'hBC   // K-character for sync, idle and skip slots
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  output logic       ready_out_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       ready_out_1,
  input  logic       ser_ready,
  output logic [7:0] ser_data,
  output logic       ser_valid,
  output logic       ser_k,
  output logic       ser_lane,
  output logic [1:0] link_state,
  output logic       sync_done
);

  localparam int unsigned        SKIP_W    = (SKIP_PERIOD < 2) ? 1 : $clog2(SKIP_PERIOD + 1);
  localparam logic [SKIP_W-1:0]  SKIP_MAX  = SKIP_W'(SKIP_PERIOD);
  localparam logic [SKIP_W-1:0]  SKIP_SAT  = '1;
  localparam logic [7:0]         SYNC_LAST = 8'(SYNC_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // What the output register is filled with on a load cycle.
  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_COMMA,
    SLOT_LANE
  } slot_t;

  state_t              state;
  state_t              state_nxt;
  slot_t               slot;
  logic                grant;       // lane chosen when slot == SLOT_LANE
  logic                last_grant;  // lane served by the most recent grant
  logic [7:0]          sync_cnt;
  logic [SKIP_W-1:0]   skip_cnt;
  logic                load;
  logic                skip_due;

  // The single output entry may be refilled when it is empty or being drained.
  assign load     = ~ser_valid | ser_ready;
  assign skip_due = (SKIP_PERIOD != 0) && (skip_cnt == SKIP_MAX);

  // State register.
  always_ff @(posedge clk_8f) begin
    // NOTE: sequential state is always written with non-blocking assignments,
    // so every flop samples values from before the edge regardless of block order.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: enable low forces the link down from any state.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_SYNC;
        ST_SYNC:   if (load && (sync_cnt == SYNC_LAST)) state_nxt = ST_ACTIVE;
        ST_ACTIVE: state_nxt = ST_ACTIVE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Slot selection: training comma, forced skip, round-robin grant or idle comma.
  always_comb begin
    slot  = SLOT_NONE;
    grant = 1'b0;
    if (enable && load) begin
      case (state)
        ST_SYNC: slot = SLOT_COMMA;
        ST_ACTIVE: begin
          if (skip_due) begin
            slot = SLOT_COMMA;
          end else if (valid_in_0 || valid_in_1) begin
            slot  = SLOT_LANE;
            // On a tie the lane not served last wins; otherwise the only requester.
            grant = (valid_in_0 && valid_in_1) ? ~last_grant : valid_in_1;
          end else begin
            slot = SLOT_COMMA;
          end
        end
        default: slot = SLOT_NONE;
      endcase
    end
  end

  assign ready_out_0 = ~reset & (slot == SLOT_LANE) & ~grant;
  assign ready_out_1 = ~reset & (slot == SLOT_LANE) &  grant;
  assign link_state  = state;
  assign sync_done   = (state == ST_ACTIVE);

  // Training, skip and arbitration bookkeeping.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sync_cnt   <= 8'd0;
      skip_cnt   <= '0;
      last_grant <= 1'b1;
    end else if (!enable || (state == ST_IDLE)) begin
      // Leaving or sitting in IDLE: the next bring-up starts a full burst.
      sync_cnt <= 8'd0;
      skip_cnt <= '0;
    end else if (state == ST_SYNC) begin
      if (slot == SLOT_COMMA) sync_cnt <= sync_cnt + 8'd1;
    end else if (slot == SLOT_LANE) begin
      last_grant <= grant;
      if (skip_cnt != SKIP_SAT) skip_cnt <= skip_cnt + SKIP_W'(1);
    end else if (slot == SLOT_COMMA) begin
      // Forced skip and idle comma both restart the data run.
      skip_cnt <= '0;
    end
  end

  // Output register: load the chosen slot, or go empty when nothing is produced.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      ser_valid <= 1'b0;
      ser_data  <= 8'h00;
      ser_k     <= 1'b0;
      ser_lane  <= 1'b0;
    end else if (load) begin
      ser_valid <= (slot != SLOT_NONE);
      if (slot == SLOT_COMMA) begin
        ser_data <= COMMA;
        ser_k    <= 1'b1;
        ser_lane <= 1'b0;
      end else if (slot == SLOT_LANE) begin
        ser_data <= grant ? data_in_1 : data_in_0;
        ser_k    <= 1'b0;
        ser_lane <= grant;
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Self-checking bench for phy_tx_sched: a slot-level model compared every
// cycle, plus literal expectations on the byte stream the serializer accepts.
module tb_phy_tx_sched;

  localparam int         SYNC_N = 4;
  localparam int         SKIP_N = 16;
  localparam logic [7:0] K      = 8'hBC;

  localparam int S_NONE  = 0;
  localparam int S_COMMA = 1;
  localparam int S_L0    = 2;
  localparam int S_L1    = 3;

  logic       clk_8f     = 1'b0;
  logic       reset      = 1'b1;
  logic       enable     = 1'b0;
  logic [7:0] data_in_0  = 8'h00;
  logic       valid_in_0 = 1'b0;
  logic [7:0] data_in_1  = 8'h00;
  logic       valid_in_1 = 1'b0;
  logic       ser_ready  = 1'b1;
  logic       ready_out_0, ready_out_1;
  logic [7:0] ser_data;
  logic       ser_valid, ser_k, ser_lane;
  logic [1:0] link_state;
  logic       sync_done;

  phy_tx_sched #(.SYNC_COUNT(SYNC_N), .SKIP_PERIOD(SKIP_N), .COMMA(K)) dut (
    .clk_8f(clk_8f), .reset(reset), .enable(enable),
    .data_in_0(data_in_0), .valid_in_0(valid_in_0), .ready_out_0(ready_out_0),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_out_1(ready_out_1),
    .ser_ready(ser_ready), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_k(ser_k), .ser_lane(ser_lane), .link_state(link_state), .sync_done(sync_done)
  );

  always #5 clk_8f = ~clk_8f;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 link down, 1 training, 2 running
  int         m_phase = 0;
  int         m_trained = 0;   // commas sent in the current training burst
  int         m_run = 0;       // data bytes since the last comma
  int         m_last = 1;      // lane served last
  logic       m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  logic       m_ok = 1'b0;
  logic       m_ol = 1'b0;
  bit         chk_en = 1'b0;

  function automatic int exp_slot();
    if (reset || !enable || (m_ov && !ser_ready) || m_phase == 0) return S_NONE;
    if (m_phase == 1) return S_COMMA;
    if (SKIP_N > 0 && m_run >= SKIP_N) return S_COMMA;
    if (valid_in_0 && valid_in_1) return (m_last == 0) ? S_L1 : S_L0;
    if (valid_in_0) return S_L0;
    if (valid_in_1) return S_L1;
    return S_COMMA;
  endfunction

  always @(posedge clk_8f) begin : model_upd
    int s;
    s = exp_slot();
    if (reset) begin
      m_phase = 0; m_trained = 0; m_run = 0; m_last = 1;
      m_ov = 1'b0; m_od = 8'h00; m_ok = 1'b0; m_ol = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (!enable) begin
        m_phase = 0; m_trained = 0; m_run = 0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_trained = 0;
      end else if (m_phase == 1 && s == S_COMMA) begin
        m_trained++;
        if (m_trained == SYNC_N) m_phase = 2;
      end else if (m_phase == 2 && s != S_NONE) begin
        if (s == S_COMMA) m_run = 0;
        else begin
          m_last = (s == S_L1) ? 1 : 0;
          m_run++;
        end
      end
      if (!m_ov || ser_ready) begin
        m_ov = (s != S_NONE);
        if (s == S_COMMA)     begin m_od = K;         m_ok = 1'b1; m_ol = 1'b0; end
        else if (s == S_L0)   begin m_od = data_in_0; m_ok = 1'b0; m_ol = 1'b0; end
        else if (s == S_L1)   begin m_od = data_in_1; m_ok = 1'b0; m_ol = 1'b1; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic took0 = 1'b0;
  logic took1 = 1'b0;

  always @(negedge clk_8f) begin : compare
    int s;
    took0 = ready_out_0;
    took1 = ready_out_1;
    if (chk_en) begin
      s = exp_slot();
      check("ready_out_0", ready_out_0, s == S_L0);
      check("ready_out_1", ready_out_1, s == S_L1);
      check("ser_valid", ser_valid, m_ov);
      check("ser_data", ser_data, m_od);
      check("ser_k", ser_k, m_ok);
      check("ser_lane", ser_lane, m_ol);
      check("link_state", link_state, m_phase);
      check("sync_done", sync_done, m_phase == 2);
    end
  end

  // Bytes actually accepted by the serializer: {k, lane, data}.
  logic [9:0] log_q[$];
  logic [9:0] dlog[$];

  always @(posedge clk_8f)
    if (!reset && ser_valid && ser_ready) log_q.push_back({ser_k, ser_lane, ser_data});

  task automatic build_dlog();
    dlog.delete();
    foreach (log_q[i]) if (!log_q[i][9]) dlog.push_back(log_q[i]);
  endtask

  function automatic logic [9:0] dget(input int i);
    return (i < dlog.size()) ? dlog[i] : 10'h3FF;
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic drive_lanes();
    valid_in_0 = (q0.size() > 0);
    data_in_0  = (q0.size() > 0) ? q0[0] : 8'h00;
    valid_in_1 = (q1.size() > 0);
    data_in_1  = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  task automatic step();
    @(posedge clk_8f);
    #2;
    if (took0 && q0.size() > 0) q0.delete(0);
    if (took1 && q1.size() > 0) q1.delete(0);
    drive_lanes();
  endtask

  task automatic bring_up(input string tag);
    int n_sync;
    int n_comma;
    n_sync = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (link_state == 2'd1) n_sync++;
    end
    check({tag, "_sync_cycles"}, n_sync, SYNC_N);
    check({tag, "_active"}, link_state, 2'd2);
    check({tag, "_sync_done"}, sync_done, 1'b1);
    n_comma = 0;
    for (int i = 0; i < SYNC_N && i < log_q.size(); i++)
      if (log_q[i] == {2'b10, K}) n_comma++;
    check({tag, "_first_commas"}, n_comma, SYNC_N);
  endtask

  task automatic wait_out(input logic [7:0] b, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (ser_valid && !ser_k && ser_data == b) found = 1'b1;
    end
    check({tag, "_wait"}, found, 1'b1);
  endtask

  initial begin
    int runs[$];
    int cur, first, last, alt_bad, ord_bad, n0, n1;
    logic prev_lane;
    bit have_prev;

    // Reset
    repeat (4) step();
    check("rst_valid", ser_valid, 1'b0);
    check("rst_data", {ser_k, ser_lane, ser_data}, 10'h000);
    check("rst_state", link_state, 2'd0);

    // Bring-up
    reset = 1'b0;
    enable = 1'b1;
    log_q.delete();
    bring_up("bringup");

    // Single lane, both directions, then idle comma
    log_q.delete();
    q0.push_back(8'hDD); drive_lanes();
    step();
    check("single0", {ser_k, ser_lane, ser_data}, 10'h0DD);
    q1.push_back(8'h5A); drive_lanes();
    step();
    check("single1", {ser_k, ser_lane, ser_data}, 10'h15A);
    step();
    check("idle_comma", {ser_valid, ser_k, ser_data}, {2'b11, K});

    // Round-robin with a 0xBC data byte
    log_q.delete();
    q0 = {8'hEC, 8'hAC};
    q1 = {8'hBC, 8'h0C};
    drive_lanes();
    repeat (6) step();
    build_dlog();
    check("rr_count", dlog.size(), 4);
    check("rr_0", dget(0), 10'h0EC);
    check("rr_1", dget(1), 10'h1BC);
    check("rr_2", dget(2), 10'h0AC);
    check("rr_3", dget(3), 10'h10C);

    // Backpressure
    log_q.delete();
    q0 = {8'h99, 8'h11};
    drive_lanes();
    wait_out(8'h99, "bp");
    ser_ready = 1'b0;
    repeat (5) step();
    check("bp_hold", {ser_valid, ser_data}, 9'h199);
    check("bp_no_take", {ready_out_0, ready_out_1}, 2'b00);
    check("bp_pending", q0.size(), 1);
    ser_ready = 1'b1;
    step();
    check("bp_next", {ser_k, ser_lane, ser_data}, 10'h011);
    repeat (2) step();
    build_dlog();
    check("bp_count", dlog.size(), 2);
    check("bp_first", dget(0), 10'h099);

    // Skip insertion with both lanes streaming
    repeat (2) step();
    log_q.delete();
    for (int i = 0; i < 20; i++) begin
      q0.push_back(8'(i));
      q1.push_back(8'(8'h80 + i));
    end
    drive_lanes();
    repeat (50) step();
    first = -1; last = -1;
    foreach (log_q[i]) if (!log_q[i][9]) begin
      if (first < 0) first = i;
      last = i;
    end
    cur = 0; alt_bad = 0; ord_bad = 0; n0 = 0; n1 = 0;
    have_prev = 1'b0; prev_lane = 1'b0;
    for (int i = first; first >= 0 && i <= last; i++) begin
      if (log_q[i][9]) begin
        runs.push_back(cur);
        cur = 0;
      end else begin
        cur++;
        if (have_prev && log_q[i][8] == prev_lane) alt_bad++;
        prev_lane = log_q[i][8];
        have_prev = 1'b1;
        if (!log_q[i][8]) begin
          if (log_q[i][7:0] != 8'(n0)) ord_bad++;
          n0++;
        end else begin
          if (log_q[i][7:0] != 8'(8'h80 + n1)) ord_bad++;
          n1++;
        end
      end
    end
    runs.push_back(cur);
    check("skip_total", n0 + n1, 40);
    check("skip_runs", runs.size(), 3);
    check("skip_run0", (runs.size() > 0) ? runs[0] : -1, 16);
    check("skip_run1", (runs.size() > 1) ? runs[1] : -1, 16);
    check("skip_run2", (runs.size() > 2) ? runs[2] : -1, 8);
    check("skip_alternate", alt_bad, 0);
    check("skip_order", ord_bad, 0);

    // Enable drop with a byte held under backpressure
    log_q.delete();
    q0.push_back(8'h77); drive_lanes();
    wait_out(8'h77, "drop");
    ser_ready = 1'b0;
    enable = 1'b0;
    repeat (2) step();
    check("drop_state", link_state, 2'd0);
    check("drop_hold", {ser_valid, ser_data}, 9'h177);
    ser_ready = 1'b1;
    step();
    check("drop_empty", ser_valid, 1'b0);
    step();
    build_dlog();
    check("drop_once", dlog.size(), 1);
    check("drop_byte", dget(0), 10'h077);

    // Re-enable repeats the full burst
    log_q.delete();
    enable = 1'b1;
    bring_up("reenable");

    // Reset pulse in the middle of SYNC
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (2) step();
    check("midsync_state", link_state, 2'd1);
    q0.push_back(8'h55); q1.push_back(8'h66); drive_lanes();
    reset = 1'b1;
    step();
    check("midrst_out", {ser_valid, ser_k, ser_lane, ser_data}, 11'h000);
    check("midrst_state", {link_state, sync_done}, 3'b000);
    check("midrst_ready", {ready_out_0, ready_out_1}, 2'b00);
    reset = 1'b0;
    log_q.delete();
    bring_up("postrst");
    repeat (3) step();
    build_dlog();
    check("postrst_count", dlog.size(), 2);
    check("postrst_first", dget(0), 10'h055);
    check("postrst_second", dget(1), 10'h166);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
